// File: rtl/start_screen_ctrl.sv
// Start-screen sequencer: frame tick, debounced start-switch flick, TITLE/COUNTDOWN/PLAY/OVER
// state machine, and blink gating of the start-text colour ahead of the pixel mux.
`timescale 1ns/1ps
module start_screen_ctrl #(
  parameter int SCREEN_HEIGHT      = 480,
  parameter int DEBOUNCE_FRAMES    = 3,
  parameter int BLINK_FRAMES       = 30,
  parameter int START_DELAY_FRAMES = 60,
  parameter int OVER_HOLD_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        video_on,
  input  logic        sw_start,
  input  logic        game_over,
  input  logic [4:0]  text_rgb,
  output logic [4:0]  rgb_out,
  output logic        text_visible,
  output logic        frame_tick,
  output logic        game_start,
  output logic        game_active,
  output logic [1:0]  state
);

  localparam int MAX_A      = (DEBOUNCE_FRAMES > BLINK_FRAMES) ? DEBOUNCE_FRAMES : BLINK_FRAMES;
  localparam int MAX_B      = (START_DELAY_FRAMES > OVER_HOLD_FRAMES) ? START_DELAY_FRAMES
                                                                       : OVER_HOLD_FRAMES;
  localparam int MAX_FRAMES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int FW         = $clog2(MAX_FRAMES) + 1;
  localparam int DW         = $clog2(DEBOUNCE_FRAMES) + 1;
  localparam int BW         = $clog2(BLINK_FRAMES) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] START_LAST = FW'(START_DELAY_FRAMES - 1);
  localparam logic [FW-1:0] OVER_LAST  = FW'(OVER_HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_TITLE     = 2'b00,
    S_COUNTDOWN = 2'b01,
    S_PLAY      = 2'b10,
    S_OVER      = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            cond, cond_q;
  logic            sync1_q, sw_sync_q;
  logic            sw_stable_q, sw_stable_d;
  logic            init_done_q, init_done_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            flick;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic            text_visible_q, text_visible_d;
  logic            game_start_q, game_start_d;
  logic            game_active_q, game_active_d;

  // Edge of the "first blanking line, column 0" condition, so a pixel lasting several
  // clocks still yields a single-clock tick.
  always_comb begin
    cond       = (pixel_y == 11'(SCREEN_HEIGHT)) && (pixel_x == 11'd0);
    frame_tick = cond & ~cond_q & ~reset;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    sw_stable_d = sw_stable_q;
    init_done_d = init_done_q;
    deb_cnt_d   = deb_cnt_q;
    flick       = 1'b0;
    if (!init_done_q) begin
      deb_cnt_d = '0;
      if (frame_tick) begin
        sw_stable_d = sw_sync_q;
        init_done_d = 1'b1;
      end
    end else if (sw_sync_q == sw_stable_q) begin
      deb_cnt_d = '0;
    end else if (frame_tick) begin
      if (deb_cnt_q == DEB_LAST) begin
        sw_stable_d = sw_sync_q;
        deb_cnt_d   = '0;
        flick       = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    game_start_d = 1'b0;
    unique case (state_q)
      S_TITLE: begin
        if (flick) begin
          state_d     = S_COUNTDOWN;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == START_LAST) begin
            state_d      = S_PLAY;
            frame_cnt_d  = '0;
            game_start_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (game_over) begin
          state_d     = S_OVER;
          frame_cnt_d = '0;
        end
      end
      S_OVER: begin
        if (frame_tick) begin
          if (frame_cnt_q == OVER_LAST) begin
            state_d     = S_TITLE;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_TITLE;
    endcase

    // Registered outputs are derived from the next state so they line up with state_q.
    unique case (state_d)
      S_TITLE: text_visible_d = blink_on_d;
      S_OVER:  text_visible_d = 1'b1;
      default: text_visible_d = 1'b0;
    endcase
    game_active_d = (state_d == S_PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_TITLE;
      cond_q         <= 1'b0;
      sync1_q        <= 1'b0;
      sw_sync_q      <= 1'b0;
      sw_stable_q    <= 1'b0;
      init_done_q    <= 1'b0;
      deb_cnt_q      <= '0;
      frame_cnt_q    <= '0;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b1;
      text_visible_q <= 1'b1;
      game_start_q   <= 1'b0;
      game_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cond_q         <= cond;
      sync1_q        <= sw_start;
      sw_sync_q      <= sync1_q;
      sw_stable_q    <= sw_stable_d;
      init_done_q    <= init_done_d;
      deb_cnt_q      <= deb_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      text_visible_q <= text_visible_d;
      game_start_q   <= game_start_d;
      game_active_q  <= game_active_d;
    end
  end

  // Colour gating stays combinational to remain pixel-aligned with text_rgb.
  assign rgb_out      = (video_on && text_visible_q) ? text_rgb : 5'd0;
  assign text_visible = text_visible_q;
  assign game_start   = game_start_q;
  assign game_active  = game_active_q;
  assign state        = state_q;

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Directed bench for start_screen_ctrl: compressed frames (pixel_y=480/pixel_x=0 held 4 clks)
// walk through blink, debounce, countdown, play, over and mid-countdown reset.
`timescale 1ns/1ps
module tb_start_screen_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixel_x, pixel_y;
  logic        video_on, sw_start, game_over;
  logic [4:0]  text_rgb;
  logic [4:0]  rgb_out;
  logic        text_visible, frame_tick, game_start, game_active;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int tick_total = 0;
  int gs_count = 0;

  start_screen_ctrl dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .sw_start(sw_start), .game_over(game_over),
    .text_rgb(text_rgb), .rgb_out(rgb_out), .text_visible(text_visible),
    .frame_tick(frame_tick), .game_start(game_start), .game_active(game_active),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (game_start === 1'b1) gs_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One compressed frame of 8 clocks; frame_tick is sampled 1ns after every negedge.
  task automatic do_frame();
    for (int s = 0; s < 8; s++) begin
      if (s == 0) begin pixel_y = 11'd480; pixel_x = 11'd0; end
      if (s == 4) pixel_x = 11'd1;
      if (s == 6) begin pixel_y = 11'd0; pixel_x = 11'd0; end
      #1;
      if (frame_tick === 1'b1) tick_total++;
      @(negedge clk);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame();
  endtask

  task automatic set_sw(input logic v);
    sw_start = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pixel_x = 11'd0; pixel_y = 11'd0; video_on = 1'b0;
    sw_start = 1'b0; game_over = 1'b0; text_rgb = 5'b11001;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_state", 32'(state), 32'd0);
    check("rst_visible", 32'(text_visible), 32'd1);
    check("rst_active", 32'(game_active), 32'd0);
    check("rst_start", 32'(game_start), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    video_on = 1'b1; #1;
    check("rgb_visible", 32'(rgb_out), 32'b11001);
    video_on = 1'b0; #1;
    check("rgb_video_off", 32'(rgb_out), 32'd0);
    @(negedge clk);

    // Tick width: high in the first clock of the line, low in the second.
    pixel_y = 11'd480; pixel_x = 11'd0; #1;
    check("tick_high", 32'(frame_tick), 32'd1);
    tick_total++;
    @(negedge clk); #1;
    check("tick_one_clk", 32'(frame_tick), 32'd0);
    repeat (3) @(negedge clk);
    pixel_y = 11'd0;
    repeat (3) @(negedge clk);

    frames(28);
    check("blink_29", 32'(text_visible), 32'd1);
    frames(1);
    check("blink_30", 32'(text_visible), 32'd0);
    video_on = 1'b1; #1;
    check("rgb_hidden", 32'(rgb_out), 32'd0);
    video_on = 1'b0;
    frames(29);
    check("blink_59", 32'(text_visible), 32'd0);
    frames(1);
    check("blink_60", 32'(text_visible), 32'd1);
    frames(30);
    check("blink_90", 32'(text_visible), 32'd0);
    frames(30);
    check("blink_120", 32'(text_visible), 32'd1);
    check("title_120", 32'(state), 32'd0);
    check("tick_count_120", 32'(tick_total), 32'd120);

    game_over = 1'b1; @(negedge clk); game_over = 1'b0; @(negedge clk);
    check("over_in_title", 32'(state), 32'd0);

    // Bounce: two differing ticks, then back low; counter must restart from zero.
    set_sw(1'b1);
    frames(2);
    set_sw(1'b0);
    frames(3);
    check("bounce_state", 32'(state), 32'd0);
    set_sw(1'b1);
    frames(2);
    check("flick_not_yet", 32'(state), 32'd0);
    frames(1);
    check("flick_countdown", 32'(state), 32'd1);
    check("cd_visible", 32'(text_visible), 32'd0);

    gs_count = 0;
    frames(59);
    check("cd_59_state", 32'(state), 32'd1);
    check("cd_59_no_start", 32'(gs_count), 32'd0);
    frames(1);
    check("play_state", 32'(state), 32'd2);
    check("play_active", 32'(game_active), 32'd1);
    check("start_pulses", 32'(gs_count), 32'd1);
    check("start_low", 32'(game_start), 32'd0);

    set_sw(1'b0);
    frames(3);
    check("flick_in_play", 32'(state), 32'd2);

    game_over = 1'b1; @(negedge clk); game_over = 1'b0;
    check("over_state", 32'(state), 32'd3);
    check("over_visible", 32'(text_visible), 32'd1);
    check("over_inactive", 32'(game_active), 32'd0);
    frames(119);
    check("over_119", 32'(state), 32'd3);
    frames(1);
    check("back_title", 32'(state), 32'd0);
    check("back_visible", 32'(text_visible), 32'd1);
    frames(29);
    check("reblink_29", 32'(text_visible), 32'd1);
    frames(1);
    check("reblink_30", 32'(text_visible), 32'd0);

    // Reset released with the switch already high: no start from the initial level.
    reset = 1'b1; sw_start = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    frames(10);
    check("sw_high_reset", 32'(state), 32'd0);
    set_sw(1'b0);
    frames(2);
    check("flick_low_wait", 32'(state), 32'd0);
    frames(1);
    check("flick_low_cd", 32'(state), 32'd1);

    frames(20);
    check("mid_cd", 32'(state), 32'd1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_visible", 32'(text_visible), 32'd1);
    check("midrst_active", 32'(game_active), 32'd0);
    check("midrst_start", 32'(game_start), 32'd0);

    frames(1);
    set_sw(1'b1);
    frames(3);
    check("fresh_cd", 32'(state), 32'd1);
    gs_count = 0;
    frames(60);
    check("fresh_play", 32'(state), 32'd2);
    check("fresh_start", 32'(gs_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
